// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle controller and its datapath.
//   Opcode[5:0]   instruction bits [31:26] from the instruction register
//   Zero          ALU zero flag
//   PC_Write, PC_Write_Cond, PC_En, IorD, Mem_Read, Mem_Write, IR_Write,
//   Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A, Instr_Done, Halted (1 bit)
//   ALU_Src_B, ALU_Op, PC_Source (2 bits), State (4 bits, current state code)
// Modports:
//   master - controller side (consumes Opcode/Zero, drives the controls)
//   slave  - datapath side   (drives Opcode/Zero, consumes the controls)
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PC_Write;
    logic       PC_Write_Cond;
    logic       PC_En;
    logic       IorD;
    logic       Mem_Read;
    logic       Mem_Write;
    logic       IR_Write;
    logic       Mem_to_Reg;
    logic       Reg_Dst;
    logic       Reg_Write;
    logic       ALU_Src_A;
    logic       Instr_Done;
    logic       Halted;
    logic [1:0] ALU_Src_B;
    logic [1:0] ALU_Op;
    logic [1:0] PC_Source;
    logic [3:0] State;

    modport master (
        input  Opcode, Zero,
        output PC_Write, PC_Write_Cond, PC_En, IorD, Mem_Read, Mem_Write,
               IR_Write, Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A,
               Instr_Done, Halted, ALU_Src_B, ALU_Op, PC_Source, State
    );

    modport slave (
        output Opcode, Zero,
        input  PC_Write, PC_Write_Cond, PC_En, IorD, Mem_Read, Mem_Write,
               IR_Write, Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A,
               Instr_Done, Halted, ALU_Src_B, ALU_Op, PC_Source, State
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for a multicycle MIPS-style datapath (R-type, LW, SW,
// BEQ, J, ADDI). Control outputs are registered together with the state so
// they are a pure function of State; only PC_En mixes in the live Zero flag.
// Ports:
//   Clock  - single clock, all updates on the rising edge
//   Reset  - asynchronous, active-high; forces FETCH
//   ctrl   - multicycle_control_if.master (Opcode/Zero in, controls out)
// Parameter:
//   ILLEGAL_HALT - 1: unknown opcode parks in HALT; 0: returns to FETCH
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    multicycle_control_if.master        ctrl
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       instr_done;
        logic       halted;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    ctrl_t      outs_q;

    // Control word for each state; anything not listed stays 0.
    function automatic ctrl_t state_outputs(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic. Opcode is only looked at in DECODE; MEM_ADDR uses the
    // copy latched on the DECODE edge so a changing IR cannot redirect it.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.Opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXEC_R:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // State, latched opcode and the registered control word move together,
    // so the outputs always describe the state currently held.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            outs_q   <= state_outputs(S_FETCH);
        end else begin
            state_q <= state_d;
            outs_q  <= state_outputs(state_d);
            if (state_q == S_DECODE) begin
                opcode_q <= ctrl.Opcode;
            end
        end
    end

    // While Reset is held the FETCH word is presented, but nothing that would
    // advance the PC or load the IR may be asserted.
    assign ctrl.PC_Write      = outs_q.pc_write & ~Reset;
    assign ctrl.IR_Write      = outs_q.ir_write & ~Reset;
    assign ctrl.PC_Write_Cond = outs_q.pc_write_cond;
    assign ctrl.PC_En         = ctrl.PC_Write | (ctrl.PC_Write_Cond & ctrl.Zero);
    assign ctrl.IorD          = outs_q.iord;
    assign ctrl.Mem_Read      = outs_q.mem_read;
    assign ctrl.Mem_Write     = outs_q.mem_write;
    assign ctrl.Mem_to_Reg    = outs_q.mem_to_reg;
    assign ctrl.Reg_Dst       = outs_q.reg_dst;
    assign ctrl.Reg_Write     = outs_q.reg_write;
    assign ctrl.ALU_Src_A     = outs_q.alu_src_a;
    assign ctrl.Instr_Done    = outs_q.instr_done;
    assign ctrl.Halted        = outs_q.halted;
    assign ctrl.ALU_Src_B     = outs_q.alu_src_b;
    assign ctrl.ALU_Op        = outs_q.alu_op;
    assign ctrl.PC_Source     = outs_q.pc_source;
    assign ctrl.State         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed sequences for both ILLEGAL_HALT settings. The stimulus process
// pushes the expected state and control word for every cycle into a queue;
// an independent monitor pops and compares on each falling clock edge (or
// immediately, for checks that fall between edges such as async reset).
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic clk;
    logic Reset;

    multicycle_control_if if0 ();
    multicycle_control_if if1 ();

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dut0 (
        .Clock (clk),
        .Reset (Reset),
        .ctrl  (if0.master)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) dut1 (
        .Clock (clk),
        .Reset (Reset),
        .ctrl  (if1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          d;
        string       tag;
        logic [3:0]  st;
        logic [18:0] o;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event chk_now;

    // Packed order: PC_Write PC_Write_Cond PC_En IorD Mem_Read Mem_Write
    // IR_Write Mem_to_Reg Reg_Dst Reg_Write ALU_Src_A Instr_Done Halted
    // ALU_Src_B[1:0] ALU_Op[1:0] PC_Source[1:0]
    logic [22:0] act0, act1;
    assign act0 = {if0.State, if0.PC_Write, if0.PC_Write_Cond, if0.PC_En, if0.IorD,
                   if0.Mem_Read, if0.Mem_Write, if0.IR_Write, if0.Mem_to_Reg,
                   if0.Reg_Dst, if0.Reg_Write, if0.ALU_Src_A, if0.Instr_Done,
                   if0.Halted, if0.ALU_Src_B, if0.ALU_Op, if0.PC_Source};
    assign act1 = {if1.State, if1.PC_Write, if1.PC_Write_Cond, if1.PC_En, if1.IorD,
                   if1.Mem_Read, if1.Mem_Write, if1.IR_Write, if1.Mem_to_Reg,
                   if1.Reg_Dst, if1.Reg_Write, if1.ALU_Src_A, if1.Instr_Done,
                   if1.Halted, if1.ALU_Src_B, if1.ALU_Op, if1.PC_Source};

    // Hand-tabulated control word per state.
    function automatic logic [18:0] exp_outs(input int st, input bit in_rst, input bit z);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done, hlt;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done, hlt} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
            9:  begin pcw = 1; psrc = 2'b10; done = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; done = 1; end
            12: hlt = 1;
            default: ;
        endcase
        if (in_rst) begin
            pcw = 0;
            irw = 0;
        end
        return {pcw, pcwc, pcw | (pcwc & z), iord, mr, mw, irw, m2r, rd, rw,
                asa, done, hlt, asb, aop, psrc};
    endfunction

    task automatic push(input bit d, input string tag, input int st, input bit in_rst);
        exp_t e;
        e.d   = d;
        e.tag = tag;
        e.st  = 4'(st);
        e.o   = exp_outs(st, in_rst, d ? if1.Zero : if0.Zero);
        sb.push_back(e);
    endtask

    // One clock: expectation for the state entered on this rising edge.
    task automatic cyc(input string tag, input int st, input bit d = 0, input bit in_rst = 0);
        @(posedge clk);
        #1;
        push(d, tag, st, in_rst);
    endtask

    // Immediate check between clock edges.
    task automatic now_chk(input string tag, input int st, input bit d, input bit in_rst);
        #1;
        push(d, tag, st, in_rst);
        -> chk_now;
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [22:0] a;
        forever begin
            @(negedge clk or chk_now);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a = e.d ? act1 : act0;
                n_tests++;
                if (a !== {e.st, e.o}) begin
                    n_fail++;
                    $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                             e.tag, a[22:19], a[18:0], e.st, e.o);
                end
            end
        end
    end

    // Stimulus
    initial begin
        Reset      = 1'b1;
        if0.Opcode = 6'b000000;
        if0.Zero   = 1'b0;
        if1.Opcode = 6'b111111;
        if1.Zero   = 1'b0;
        #2;
        now_chk("reset_state", 0, 0, 1);
        repeat (2) @(negedge clk);
        #1 Reset = 1'b0;
        now_chk("release_fetch", 0, 0, 0);

        // R-type: 0,1,6,7,0
        cyc("r_decode", 1); cyc("r_exec", 6); cyc("r_wb", 7); cyc("r_fetch", 0);

        // LW: 0,1,2,3,4,0
        if0.Opcode = 6'b100011;
        cyc("lw_decode", 1); cyc("lw_addr", 2); cyc("lw_read", 3);
        cyc("lw_wb", 4); cyc("lw_fetch", 0);

        // SW with opcode changed to R-type during MEM_ADDR: still 2->5
        if0.Opcode = 6'b101011;
        cyc("sw_decode", 1); cyc("sw_addr", 2);
        if0.Opcode = 6'b000000;
        cyc("sw_write", 5); cyc("sw_fetch", 0);

        // BEQ taken then not taken
        if0.Opcode = 6'b000100;
        if0.Zero   = 1'b1;
        cyc("beq1_decode", 1); cyc("beq1_branch_pcen1", 8); cyc("beq1_fetch", 0);
        if0.Zero   = 1'b0;
        cyc("beq0_decode", 1); cyc("beq0_branch_pcen0", 8); cyc("beq0_fetch", 0);

        // J
        if0.Opcode = 6'b000010;
        cyc("j_decode", 1); cyc("j_jump", 9); cyc("j_fetch", 0);

        // ADDI
        if0.Opcode = 6'b001000;
        cyc("addi_decode", 1); cyc("addi_exec", 10); cyc("addi_wb", 11); cyc("addi_fetch", 0);

        // LW aborted by async reset during MEM_READ
        if0.Opcode = 6'b100011;
        cyc("lwr_decode", 1); cyc("lwr_addr", 2); cyc("lwr_read", 3);
        @(negedge clk);
        #1 Reset = 1'b1;
        now_chk("async_reset_midcycle", 0, 0, 1);
        cyc("reset_held", 0, 0, 1);
        @(negedge clk);
        #1 Reset = 1'b0;
        now_chk("release2_fetch", 0, 0, 0);
        cyc("after_abort_decode", 1); cyc("after_abort_addr", 2);
        cyc("after_abort_read", 3);

        // Illegal opcode with ILLEGAL_HALT=1: halts until reset
        if0.Opcode = 6'b111111;
        cyc("after_abort_wb", 4); cyc("after_abort_fetch", 0);
        cyc("ill_decode", 1);
        cyc("ill_halt", 12);
        for (int i = 0; i < 20; i++) cyc($sformatf("halt_hold%0d", i), 12);
        @(negedge clk);
        #1 Reset = 1'b1;
        now_chk("halt_reset", 0, 0, 1);
        cyc("halt_reset_held", 0, 0, 1);

        // Illegal opcode with ILLEGAL_HALT=0: DECODE back to FETCH
        @(negedge clk);
        #1 Reset = 1'b0;
        now_chk("nh_release", 0, 1, 0);
        cyc("nh_decode", 1, 1); cyc("nh_fetch", 0, 1);
        cyc("nh_decode2", 1, 1); cyc("nh_fetch2", 0, 1);

        // Drain with a bounded wait
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1: 1 = unknown opcode enters HALT; 0 = unknown opcode returns to FETCH.
REQ-002 Clock  in  1  single clock; all state updates on posedge.
REQ-003 Reset  in  1  asynchronous, active-high; forces FETCH immediately.
REQ-004 Opcode  in  6  instruction bits [31:26] from the instruction register; sampled only in DECODE.
REQ-005 Zero  in  1  ALU zero flag; used only in BRANCH.
REQ-006 Outputs, 1 bit each: PC_Write, PC_Write_Cond, PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A, Instr_Done, Halted.
REQ-007 Outputs, 2 bits each: ALU_Src_B, ALU_Op, PC_Source; State out, 4 bits: current state code.

Function
REQ-008 Moore FSM; every output except PC_En is a pure function of State.
REQ-009 PC_En SHALL equal PC_Write | (PC_Write_Cond & Zero), combinationally.
REQ-010 State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, HALT=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-011 Transitions: FETCH->DECODE unconditionally.
REQ-012 DECODE: 000000->EXEC_R; 100011 or 101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP; 001000->ADDI_EXEC; any other->HALT if ILLEGAL_HALT=1, else FETCH.
REQ-013 MEM_ADDR->MEM_READ if the opcode latched in DECODE is 100011, else MEM_WRITE; the FSM SHALL latch the opcode in an internal register on the DECODE edge.
REQ-014 MEM_READ->MEM_WB; EXEC_R->R_WB; ADDI_EXEC->ADDI_WB.
REQ-015 MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB SHALL go to FETCH.
REQ-016 HALT SHALL hold until Reset.
REQ-017 Outputs not listed for a state are 0.
REQ-018 FETCH drives: Mem_Read=1, IR_Write=1, ALU_Src_B=01, PC_Write=1.
REQ-019 DECODE drives ALU_Src_B=11.
REQ-020 MEM_ADDR and ADDI_EXEC drive: ALU_Src_A=1, ALU_Src_B=10.
REQ-021 MEM_READ drives: Mem_Read=1, IorD=1.
REQ-022 MEM_WB drives: Reg_Write=1, Mem_to_Reg=1.
REQ-023 MEM_WRITE drives: Mem_Write=1, IorD=1.
REQ-024 EXEC_R drives: ALU_Src_A=1, ALU_Op=10.
REQ-025 R_WB drives: Reg_Write=1, Reg_Dst=1.
REQ-026 BRANCH drives: ALU_Src_A=1, ALU_Op=01, PC_Write_Cond=1, PC_Source=01.
REQ-027 JUMP drives: PC_Write=1, PC_Source=10.
REQ-028 ADDI_WB drives Reg_Write=1.
REQ-029 HALT drives Halted=1 only.
REQ-030 Instr_Done SHALL be 1 exactly in MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB.
REQ-031 Latency in cycles from FETCH through the Instr_Done cycle: R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4.
REQ-032 Reg_Write and Mem_Write SHALL never both be 1; Reg_Write SHALL be 1 for exactly one cycle per register-writing instruction.
REQ-033 Opcode and Zero changes outside DECODE and BRANCH respectively SHALL have no effect on State.

Reset
REQ-034 Reset=1 SHALL force State=FETCH and clear the latched opcode asynchronously, without waiting for a clock edge.
REQ-035 While Reset=1, outputs SHALL carry FETCH values, except PC_Write=0, PC_En=0 and IR_Write=0.
REQ-036 First edge after Reset deasserts SHALL move FETCH->DECODE.
REQ-037 Reset asserted in any state, including HALT or mid-instruction, SHALL abort the instruction with no further Reg_Write or Mem_Write.

Verification
REQ-038 Reset release with Opcode=000000 -> states 0,1,6,7,0; Reg_Write=1 and Reg_Dst=1 only in state 7; Instr_Done in state 7.
REQ-039 Opcode=100011 -> states 0,1,2,3,4,0; Mem_Read=1 in states 0 and 3; IorD=1 in state 3; Reg_Write=1 and Mem_to_Reg=1 in state 4.
REQ-040 Opcode=101011, then Opcode changed to 000000 during MEM_ADDR -> path still 2->5; Mem_Write=1 for one cycle; Reg_Write stays 0.
REQ-041 Opcode=000100 with Zero=1, then Zero=0 -> PC_En=1 in BRANCH for the first; PC_En=0 in BRANCH for the second; both return to FETCH after 3 cycles.
REQ-042 Opcode=111111 -> ILLEGAL_HALT=1: State=12, Halted=1 held for 20 cycles, then Reset -> State=0; ILLEGAL_HALT=0: State 1->0.
REQ-043 Reset asserted mid-cycle during MEM_READ -> State=0 before the next edge; no Reg_Write pulse follows.
